// File: rtl/router_pkg.sv
// Shared definitions for the 1x3 router: packet-transmitter states, field
// widths and the header packing used by both the transmit and receive sides.
package router_pkg;

  localparam int ADDR_W = 2;
  localparam int LEN_W  = 6;
  localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_HEADER,
    ST_PAYLOAD,
    ST_PARITY,
    ST_GAP
  } tx_state_e;

  function automatic logic [7:0] pack_header(input logic [ADDR_W-1:0] addr,
                                             input logic [LEN_W-1:0]  len);
    return {len, addr};
  endfunction

endpackage

// File: rtl/router_pkt_buf.sv
// 64x8 payload buffer: synchronous write, asynchronous read. Contents are
// not reset; every byte is rewritten before it is read for a packet.
module router_pkt_buf
  import router_pkg::*;
(
  input  logic             clock,
  input  logic             we_i,
  input  logic [LEN_W-1:0] waddr_i,
  input  logic [7:0]       wdata_i,
  input  logic [LEN_W-1:0] raddr_i,
  output logic [7:0]       rdata_o
);

  logic [7:0] mem_q [0:(1<<LEN_W)-1];

  always_ff @(posedge clock) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/router_pkt_tx.sv
// Router input-side packet transmitter: buffers a payload, then sends
// header, payload and parity contiguously under busy back-pressure.
module router_pkt_tx
  import router_pkg::*;
#(
  parameter int GAP_CYCLES = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              cmd_bad_parity,
  output logic              cmd_err,
  input  logic              pl_valid,
  input  logic [7:0]        pl_data,
  output logic              pl_ready,
  input  logic              busy,
  output logic              pkt_valid,
  output logic [7:0]        pkt_data,
  output logic              tx_done
);

  localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

  tx_state_e         state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              badp_q, badp_d;
  logic [LEN_W-1:0]  idx_q, idx_d;
  logic [7:0]        par_q, par_d;
  logic [3:0]        gap_q, gap_d;
  logic              pv_q, pv_d;
  logic [7:0]        pd_q, pd_d;
  logic              buf_we;
  logic [7:0]        buf_rdata;
  logic [7:0]        par_out;

  // Read address follows the next index so the registered output is loaded
  // with the byte that will be on the wire after this edge.
  router_pkt_buf u_buf (
    .clock   (clock),
    .we_i    (buf_we),
    .waddr_i (idx_q),
    .wdata_i (pl_data),
    .raddr_i (idx_d),
    .rdata_o (buf_rdata)
  );

  assign par_out = par_q ^ {7'b0, badp_q};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      badp_q  <= 1'b0;
      idx_q   <= '0;
      par_q   <= '0;
      gap_q   <= '0;
      pv_q    <= 1'b0;
      pd_q    <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      badp_q  <= badp_d;
      idx_q   <= idx_d;
      par_q   <= par_d;
      gap_q   <= gap_d;
      pv_q    <= pv_d;
      pd_q    <= pd_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    len_d     = len_q;
    badp_d    = badp_q;
    idx_d     = idx_q;
    par_d     = par_q;
    gap_d     = gap_q;
    pv_d      = pv_q;
    pd_d      = pd_q;
    cmd_ready = 1'b0;
    cmd_err   = 1'b0;
    pl_ready  = 1'b0;
    tx_done   = 1'b0;
    buf_we    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          if (cmd_addr == ADDR_INVALID) begin
            cmd_err = 1'b1;
          end else begin
            addr_d = cmd_addr;
            len_d  = cmd_len;
            badp_d = cmd_bad_parity;
            idx_d  = '0;
            par_d  = pack_header(cmd_addr, cmd_len);
            if (cmd_len == '0) begin
              state_d = ST_HEADER;
              pv_d    = 1'b1;
              pd_d    = pack_header(cmd_addr, cmd_len);
            end else begin
              state_d = ST_LOAD;
            end
          end
        end
      end
      ST_LOAD: begin
        pl_ready = 1'b1;
        if (pl_valid) begin
          buf_we = 1'b1;
          par_d  = par_q ^ pl_data;
          if (idx_q == len_q - 6'd1) begin
            idx_d   = '0;
            state_d = ST_HEADER;
            pv_d    = 1'b1;
            pd_d    = pack_header(addr_q, len_q);
          end else begin
            idx_d = idx_q + 6'd1;
          end
        end
      end
      ST_HEADER: begin
        if (!busy) begin
          if (len_q == '0) begin
            state_d = ST_PARITY;
            pv_d    = 1'b0;
            pd_d    = par_out;
          end else begin
            state_d = ST_PAYLOAD;
            pd_d    = buf_rdata;
          end
        end
      end
      ST_PAYLOAD: begin
        if (!busy) begin
          if (idx_q == len_q - 6'd1) begin
            state_d = ST_PARITY;
            pv_d    = 1'b0;
            pd_d    = par_out;
          end else begin
            idx_d = idx_q + 6'd1;
            pd_d  = buf_rdata;
          end
        end
      end
      ST_PARITY: begin
        if (!busy) begin
          tx_done = 1'b1;
          pd_d    = '0;
          gap_d   = '0;
          state_d = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) state_d = ST_IDLE;
        else                   gap_d   = gap_q + 4'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign pkt_valid = pv_q;
  assign pkt_data  = pd_q;

endmodule

// File: tb/tb_router_pkt_tx.sv
// Directed bench for router_pkt_tx: table of packets with hand-computed
// header/parity, plus busy, invalid-address and mid-packet reset sequences.
module tb_router_pkt_tx;

  logic       clock = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_addr;
  logic [5:0] cmd_len;
  logic       cmd_bad_parity;
  logic       cmd_err;
  logic       pl_valid;
  logic [7:0] pl_data;
  logic       pl_ready;
  logic       busy;
  logic       pkt_valid;
  logic [7:0] pkt_data;
  logic       tx_done;

  int n_chk  = 0;
  int n_fail = 0;

  router_pkt_tx #(.GAP_CYCLES(2)) dut (
    .clock          (clock),
    .reset          (reset),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_addr       (cmd_addr),
    .cmd_len        (cmd_len),
    .cmd_bad_parity (cmd_bad_parity),
    .cmd_err        (cmd_err),
    .pl_valid       (pl_valid),
    .pl_data        (pl_data),
    .pl_ready       (pl_ready),
    .busy           (busy),
    .pkt_valid      (pkt_valid),
    .pkt_data       (pkt_data),
    .tx_done        (tx_done)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [1:0] addr;
    logic [5:0] len;
    logic       bad;
    logic [7:0] pl [0:2];
    logic [7:0] hdr;
    logic [7:0] par;
  } vec_t;

  vec_t vecs [0:4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue the command, then stream the payload; returns at the negedge where
  // the header is first visible.
  task automatic send(input vec_t v);
    @(negedge clock);
    cmd_valid = 1'b1; cmd_addr = v.addr; cmd_len = v.len; cmd_bad_parity = v.bad;
    #1 check("cmd_ready_idle", cmd_ready, 1);
    @(negedge clock);
    cmd_valid = 1'b0;
    for (int i = 0; i < int'(v.len); i++) begin
      pl_valid = 1'b1; pl_data = v.pl[i];
      #1 check("pl_ready_load", pl_ready, 1);
      @(negedge clock);
    end
    pl_valid = 1'b0;
  endtask

  // Walk the transmitted bytes cycle by cycle, optionally holding busy for
  // busy_n cycles during byte busy_k, then check the gap and cmd_ready.
  task automatic expect_tx(input vec_t v, input int busy_k, input int busy_n);
    logic [7:0] exp [0:4];
    int n, hold;
    n = int'(v.len) + 2;
    exp[0] = v.hdr;
    for (int i = 0; i < int'(v.len); i++) exp[i+1] = v.pl[i];
    exp[n-1] = v.par;
    for (int k = 0; k < n; k++) begin
      hold = (k == busy_k) ? busy_n : 0;
      for (int h = 0; h <= hold; h++) begin
        busy = (h < hold);
        #1;
        check("pkt_valid", pkt_valid, (k < n-1) ? 1 : 0);
        check("pkt_data", pkt_data, exp[k]);
        check("tx_done", tx_done, (k == n-1 && h == hold) ? 1 : 0);
        check("pl_ready_tx", pl_ready, 0);
        @(negedge clock);
      end
      busy = 1'b0;
    end
    for (int g = 0; g < 2; g++) begin
      #1;
      check("gap_valid", pkt_valid, 0);
      check("gap_data", pkt_data, 0);
      check("gap_ready", cmd_ready, 0);
      @(negedge clock);
    end
    #1 check("ready_after_gap", cmd_ready, 1);
  endtask

  initial begin
    vecs[0] = '{addr:2'd2, len:6'd3, bad:1'b0, pl:'{8'hA1, 8'h52, 8'h3C}, hdr:8'h0E, par:8'hC1};
    vecs[1] = '{addr:2'd1, len:6'd0, bad:1'b0, pl:'{8'h00, 8'h00, 8'h00}, hdr:8'h01, par:8'h01};
    vecs[2] = '{addr:2'd2, len:6'd3, bad:1'b1, pl:'{8'hA1, 8'h52, 8'h3C}, hdr:8'h0E, par:8'hC0};
    vecs[3] = '{addr:2'd0, len:6'd2, bad:1'b0, pl:'{8'hFF, 8'h00, 8'h00}, hdr:8'h08, par:8'hF7};
    vecs[4] = '{addr:2'd1, len:6'd1, bad:1'b0, pl:'{8'h5A, 8'h00, 8'h00}, hdr:8'h05, par:8'h5F};

    reset = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; cmd_bad_parity = 1'b0;
    pl_valid = 1'b0; pl_data = '0; busy = 1'b0;
    repeat (2) @(negedge clock);
    check("rst_pkt_valid", pkt_valid, 0);
    check("rst_pkt_data", pkt_data, 0);
    check("rst_pl_ready", pl_ready, 0);
    check("rst_tx_done", tx_done, 0);
    check("rst_cmd_err", cmd_err, 0);
    reset = 1'b0;
    #1 check("cmd_ready_after_rst", cmd_ready, 1);

    for (int t = 0; t < 5; t++) begin
      send(vecs[t]);
      expect_tx(vecs[t], -1, 0);
    end

    // busy held 3 cycles while byte 52 is on the wire
    send(vecs[0]);
    expect_tx(vecs[0], 2, 3);

    // invalid address: error pulse, nothing transmitted
    @(negedge clock);
    cmd_valid = 1'b1; cmd_addr = 2'd3; cmd_len = 6'd5; cmd_bad_parity = 1'b0;
    #1 check("cmd_err_pulse", cmd_err, 1);
    @(negedge clock);
    cmd_valid = 1'b0;
    #1;
    check("cmd_err_clear", cmd_err, 0);
    check("cmd_ready_after_err", cmd_ready, 1);
    for (int c = 0; c < 3; c++) begin
      check("err_pkt_valid", pkt_valid, 0);
      check("err_pl_ready", pl_ready, 0);
      @(negedge clock);
      #1;
    end

    // reset mid-payload, right after A1 appears
    send(vecs[0]);
    #1 check("hdr_before_rst", pkt_data, 8'h0E);
    @(negedge clock);
    #1 check("a1_before_rst", pkt_data, 8'hA1);
    #1 reset = 1'b1;
    #1;
    check("async_rst_valid", pkt_valid, 0);
    check("async_rst_data", pkt_data, 0);
    check("async_rst_tx_done", tx_done, 0);
    @(negedge clock);
    check("rst_hold_tx_done", tx_done, 0);
    reset = 1'b0;
    #1 check("ready_post_rst", cmd_ready, 1);
    check("valid_post_rst", pkt_valid, 0);
    send(vecs[4]);
    expect_tx(vecs[4], -1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
